// File: rtl/mem_in_banked.sv
// Banked single-port memory with a host port and a read-burst stream engine.
// Latency: host read data on Q 1 cycle after the access; the first stream word is valid 2 cycles after start.
// Backpressure: host accesses preempt stream reads; stream reads are credit-limited by a 2-entry output FIFO, so out_ready stalls never drop words.

module mem_in_banked_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] cnt
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld & pop_rdy;

  // Storage, pointers and occupancy; the producer never pushes when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_vld) - CNT_W'(do_pop);
    end
  end
endmodule

module mem_in_banked #(
  parameter int DATA_W = 8,
  parameter int BANK_AW = 8,
  parameter int NUM_BANKS = 128,
  localparam int BANK_W = $clog2(NUM_BANKS),
  localparam int ADDR_W = BANK_AW + BANK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     rem;
  logic                start_acc;
  logic                str_go;
  logic                credit_ok;
  logic                host_wr;
  logic                host_rd;
  logic                acc_vld;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W:0]     cur_rem;
  logic [ADDR_W-1:0]   acc_addr;
  logic [BANK_W-1:0]   acc_bank;
  logic [BANK_AW-1:0]  acc_row;
  logic [BANK_W-1:0]   sel_q;
  logic                host_rd_q;
  logic                str_rd_q;
  logic                last_q;
  logic [DATA_W-1:0]   bank_rd_dat [NUM_BANKS];
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   q_hold;
  logic                fifo_vld;
  logic [DATA_W:0]     fifo_dat;
  logic [1:0]          fifo_cnt;
  logic                fifo_last;
  logic                pop;
  logic [2:0]          occ;

  assign host_wr  = ~CEN & ~WEN;
  assign host_rd  = ~CEN & WEN;
  assign rd_mux   = bank_rd_dat[sel_q];
  assign pop      = fifo_vld & out_ready;
  assign fifo_last = fifo_dat[DATA_W];

  // Arbitration: host wins any cycle with CEN low; the stream reads only with FIFO credit.
  // A word popped this cycle frees its slot before the next issued read can land, so the
  // pop is credited back immediately to sustain one word per cycle.
  always_comb begin
    start_acc = (state == IDLE) && start && !done;
    cur_addr  = (state == IDLE) ? base : rd_addr;
    cur_rem   = (state == IDLE) ? len : rem;
    occ       = {1'b0, fifo_cnt} + {2'b00, str_rd_q};
    credit_ok = occ < (3'd2 + {2'b00, pop});
    str_go    = (start_acc || (state == RUN)) && (cur_rem != '0) && CEN && credit_ok;
    acc_vld   = ~CEN | str_go;
    acc_addr  = ~CEN ? A : cur_addr;
    acc_bank  = acc_addr[ADDR_W-1:BANK_AW];
    acc_row   = acc_addr[BANK_AW-1:0];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] ram [2**BANK_AW];
    logic [DATA_W-1:0] ram_q;
    logic              bank_en;

    assign bank_en = acc_vld && (acc_bank == BANK_W'(b));

    // Single port per bank: only the addressed bank is enabled; write or synchronous read.
    always_ff @(posedge clk) begin
      if (bank_en) begin
        if (host_wr) ram[acc_row] <= D;
        else         ram_q <= ram[acc_row];
      end
    end

    assign bank_rd_dat[b] = ram_q;
  end

  // Read pipeline: remember who owns the bank output next cycle, and hold the last host read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rd_q <= 1'b0;
      str_rd_q  <= 1'b0;
      last_q    <= 1'b0;
      sel_q     <= '0;
      q_hold    <= '0;
    end else begin
      host_rd_q <= host_rd;
      str_rd_q  <= str_go;
      last_q    <= str_go && (cur_rem == (ADDR_W+1)'(1));
      if (acc_vld) sel_q <= acc_bank;
      if (host_rd_q) q_hold <= rd_mux;
    end
  end

  assign Q = host_rd_q ? rd_mux : q_hold;

  mem_in_banked_fifo #(.W(DATA_W + 1), .DEPTH(2)) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (str_rd_q),
    .push_dat ({last_q, rd_mux}),
    .pop_rdy  (out_ready),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .cnt      (fifo_cnt)
  );

  assign out_valid = fifo_vld;
  assign out_data  = fifo_vld ? fifo_dat[DATA_W-1:0] : '0;
  assign out_last  = fifo_vld & fifo_last;

  // Burst FSM: the first read issues in the start cycle itself so data is valid two cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              rd_addr <= cur_addr + ADDR_W'(str_go);
              rem     <= cur_rem - (ADDR_W+1)'(str_go);
            end
          end
        end
        RUN: begin
          rd_addr <= cur_addr + ADDR_W'(str_go);
          rem     <= cur_rem - (ADDR_W+1)'(str_go);
          if ((rem == '0) || (str_go && (rem == (ADDR_W+1)'(1)))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && fifo_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_in_banked.sv
// Directed bench for mem_in_banked: host port, bank-crossing and wrapping bursts,
// host interleave, zero-length and ignored starts, and reset mid-burst.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_in_banked;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN;
  logic        WEN;
  logic [14:0] A;
  logic [7:0]  D;
  logic [7:0]  Q;
  logic        start;
  logic [14:0] base;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_in_banked dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q),
    .start(start), .base(base), .len(len), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [14:0] a, input logic [7:0] d);
    CEN = 1'b0; WEN = 1'b0; A = a; D = d;
    step();
    CEN = 1'b1; WEN = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_Q got %h want 00", Q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_host_rw();
    host_write(15'h0102, 8'hA5);
    CEN = 1'b0; WEN = 1'b1; A = 15'h0102;
    step();
    CEN = 1'b1;
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL host_read got %h want a5", Q); end
    host_write(15'h0102, 8'h3C);
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL host_q_hold got %h want a5", Q); end
    CEN = 1'b0; WEN = 1'b1; A = 15'h0102;
    step();
    CEN = 1'b1;
    checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL host_reread got %h want 3c", Q); end
  endtask

  task automatic test_burst_bank();
    logic       exp_vld  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_dat  [7] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    logic       exp_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 512; k++) host_write(15'(k), 8'(k));
    out_ready = 1'b1; base = 15'h00FE; len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (out_valid !== exp_vld[i]) begin errors++; $display("FAIL bank_valid c%0d got %b want %b", i + 1, out_valid, exp_vld[i]); end
      checks++; if (out_data !== exp_dat[i]) begin errors++; $display("FAIL bank_data c%0d got %h want %h", i + 1, out_data, exp_dat[i]); end
      checks++; if (out_last !== exp_last[i]) begin errors++; $display("FAIL bank_last c%0d got %b want %b", i + 1, out_last, exp_last[i]); end
      checks++; if (done !== exp_done[i]) begin errors++; $display("FAIL bank_done c%0d got %b want %b", i + 1, done, exp_done[i]); end
      checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL bank_busy c%0d got %b want %b", i + 1, busy, exp_busy[i]); end
      step();
    end
  endtask

  task automatic test_wrap_stall();
    logic [7:0]  exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [15:0] rdy_pat = 16'b1011_0010_1101_0100;
    int          got = 0;
    int          dc = 0;
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h00;
    host_write(15'h7FFE, 8'h11);
    host_write(15'h7FFF, 8'h22);
    host_write(15'h0000, 8'h33);
    host_write(15'h0001, 8'h44);
    out_ready = 1'b0; base = 15'h7FFE; len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      out_ready = rdy_pat[i % 16];
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL wrap_stable c%0d got %b/%h want 1/%h", i, out_valid, out_data, held); end
      end
      if (out_valid && out_ready) begin
        if (got < 4) begin
          checks++; if (out_data !== exp[got]) begin errors++; $display("FAIL wrap_data w%0d got %h want %h", got, out_data, exp[got]); end
          checks++; if (out_last !== (got == 3)) begin errors++; $display("FAIL wrap_last w%0d got %b want %b", got, out_last, (got == 3)); end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (done) dc++;
      step();
    end
    out_ready = 1'b1;
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got); end
    checks++; if (dc != 1) begin errors++; $display("FAIL wrap_done_pulses got %0d want 1", dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got %b want 0", busy); end
  endtask

  task automatic test_host_interleave();
    logic [7:0] exp [16];
    int         got = 0;
    int         dc = 0;
    logic       rd_prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      host_write(15'h0200 + 15'(i), 8'h80 + 8'(i));
      exp[i] = 8'h80 + 8'(i);
    end
    exp[15] = 8'hEE;
    out_ready = 1'b1; base = 15'h0200; len = 16'd16;
    for (int c = 0; c < 80; c++) begin
      start = (c == 0);
      CEN = 1'b1; WEN = 1'b1;
      if (c % 3 == 2) begin
        CEN = 1'b0;
        if (c == 2) begin WEN = 1'b0; A = 15'h020F; D = 8'hEE; end
        else begin WEN = 1'b1; A = 15'h0102; end
      end
      if (rd_prev) begin
        checks++; if (Q !== 8'h02) begin errors++; $display("FAIL inter_host_read c%0d got %h want 02", c, Q); end
      end
      rd_prev = (c % 3 == 2) && (c != 2);
      if (out_valid && out_ready) begin
        if (got < 16) begin
          checks++; if (out_data !== exp[got]) begin errors++; $display("FAIL inter_data w%0d got %h want %h", got, out_data, exp[got]); end
          checks++; if (out_last !== (got == 15)) begin errors++; $display("FAIL inter_last w%0d got %b want %b", got, out_last, (got == 15)); end
        end
        got++;
      end
      if (done) dc++;
      step();
    end
    start = 1'b0; CEN = 1'b1; WEN = 1'b1;
    checks++; if (got != 16) begin errors++; $display("FAIL inter_count got %0d want 16", got); end
    checks++; if (dc != 1) begin errors++; $display("FAIL inter_done_pulses got %0d want 1", dc); end
  endtask

  task automatic test_len0_ignore();
    logic [7:0] exp [2] = '{8'h33, 8'h44};
    int         got = 0;
    int         dc = 0;
    out_ready = 1'b1; base = 15'h0000; len = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len0_valid got %b want 0", out_valid); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_pulse got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len0_valid_later got %b want 0", out_valid); end
    base = 15'h0000; len = 16'd2; start = 1'b1;
    step();
    base = 15'h0100; len = 16'd8;
    for (int i = 0; i < 20 && dc == 0; i++) begin
      if (out_valid) begin
        if (got < 2) begin
          checks++; if (out_data !== exp[got]) begin errors++; $display("FAIL ignore_data w%0d got %h want %h", got, out_data, exp[got]); end
        end
        got++;
      end
      if (done) dc++;
      step();
    end
    start = 1'b0;
    checks++; if (got != 2) begin errors++; $display("FAIL ignore_count got %0d want 2", got); end
    checks++; if (dc != 1) begin errors++; $display("FAIL ignore_done got %0d want 1", dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after_done got %b want 0", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_late got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid_late got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int         got = 0;
    int         dc = 0;
    out_ready = 1'b0; base = 15'h0200; len = 16'd16; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL rstmid_Q got %h want 00", Q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", out_data); end
    rst_n = 1'b1; out_ready = 1'b1; base = 15'h00FE; len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_restart_busy got %b want 1", busy); end
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        if (got < 4) begin
          checks++; if (out_data !== exp[got]) begin errors++; $display("FAIL rstmid_data w%0d got %h want %h", got, out_data, exp[got]); end
          checks++; if (out_last !== (got == 3)) begin errors++; $display("FAIL rstmid_last w%0d got %b want %b", got, out_last, (got == 3)); end
        end
        got++;
      end
      if (done) dc++;
      step();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", got); end
    checks++; if (dc != 1) begin errors++; $display("FAIL rstmid_done_pulses got %0d want 1", dc); end
  endtask

  initial begin
    rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; A = '0; D = '0;
    start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_host_rw();
    test_burst_bank();
    test_wrap_stall();
    test_host_interleave();
    test_len0_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_in_banked.md
MEM_IN_BANKED -- requirements
Module: mem_in_banked

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter BANK_AW, default 8, address width inside one bank (bank depth 2^BANK_AW).
REQ-003 Parameter NUM_BANKS, default 128, bank count; power of two, >= 2; localparam ADDR_W = BANK_AW + log2(NUM_BANKS).
REQ-004 Ports, clock and reset first, shall be exactly as follows.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- CEN  in  1  host chip enable, active low.
- WEN  in  1  host write enable, active low (0 = write, 1 = read).
- A  in  ADDR_W  host address; A[ADDR_W-1:BANK_AW] = bank, A[BANK_AW-1:0] = row.
- D  in  DATA_W  host write data.
- Q  out  DATA_W  host read data.
- start  in  1  burst request pulse.
- base  in  ADDR_W  burst start address, sampled with start.
- len  in  ADDR_W+1  burst word count, sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_W  stream word.
- out_last  out  1  marks the final word of a burst.

Function
REQ-005 Storage shall be NUM_BANKS banks of 2^BANK_AW x DATA_W, each with a synchronous read. In any cycle, only the bank addressed by the winning access shall be enabled.
REQ-006 Host write (CEN=0, WEN=0) shall store D at A on that edge; Q shall hold.
REQ-007 Host read (CEN=0, WEN=1) shall drive Q with mem[A] exactly 1 cycle later. The bank select shall be registered with the access, and Q shall hold until the next host read.
REQ-008 Host access shall have priority: in any cycle with CEN=0 the stream engine shall issue no read and its address shall not advance.
REQ-009 FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 and len!=0 -> latch base/len, go to RUN, busy=1 from the next cycle.
- IDLE: start=1 and len=0 -> done=1 next cycle, no beats, stay IDLE.
- RUN: go to DRAIN once the last read has been issued.
- DRAIN: go to IDLE when the final word handshakes (out_valid & out_ready & out_last). done=1 in that following cycle; busy drops in the same cycle.
REQ-010 start shall be ignored while busy=1 or while done=1.
REQ-011 Stream reads shall issue in address order base, base+1, ... base+len-1, with the address incremented modulo 2^ADDR_W (wrap from all-ones to 0). Bank crossings shall be seamless.
REQ-012 Read data shall land in a 2-entry output FIFO.
- A read shall issue only when (FIFO occupancy + reads in flight) < 2 and CEN=1.
- No word shall ever be dropped or duplicated under any out_ready pattern.
REQ-013 out_valid = FIFO non-empty; out_data/out_last come from the FIFO head. A word transfers on out_valid & out_ready.
REQ-014 out_data shall be stable while out_valid=1 and out_ready=0.
REQ-015 With out_ready held at 1 and CEN held at 1, throughput shall be 1 word/cycle, and the first out_valid shall appear 2 cycles after the start cycle.
REQ-016 out_last shall be 1 only on word number len; exactly len handshakes shall occur per burst.
REQ-017 A host write to an address the burst has not yet read shall be visible to the burst. Data already read shall not change.

Reset
REQ-018 When rst_n=0 at an edge:
- Outputs: Q=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0.
- Internal: FSM=IDLE, FIFO empty, in-flight reads discarded.
- Memory contents: unspecified/preserved.
REQ-019 Reset mid-burst shall abort the burst with no done pulse; start shall be accepted on the first cycle after rst_n returns to 1.

Verification
REQ-020 Host write 0xA5 to A=0x0102, then read A=0x0102 -> Q=0xA5 one cycle after the read; Q holds through a following write.
REQ-021 Preload mem[k]=k[7:0] for k=0..511; burst base=0x00FE, len=4, out_ready=1 -> data FE,FF,00,01 (crossing bank 0->1) on 4 consecutive cycles; out_last on 01; done 1 cycle after.
REQ-022 Burst base=0x7FFE, len=4 -> addresses 7FFE, 7FFF, 0000, 0001 (wrap); out_ready toggled randomly -> same 4 words, none lost or repeated, data stable while stalled.
REQ-023 Host reads/writes every 3rd cycle during a len=16 burst -> stream stalls on host cycles; all 16 words correct; a host write to an unread stream address is seen by the stream.
REQ-024 start with len=0 -> done=1 next cycle, busy stays 0, no out_valid; start while busy -> ignored.
REQ-025 rst_n=0 for 1 cycle mid-burst -> all outputs 0 next cycle, no done; a new burst then completes correctly.
